// File: rtl/bouncing_box_renderer.sv
// ---------------------------------------------------------------------------
// bouncing_box_renderer
//
// Pixel-generation stage that sits behind a 640x480 VGA timing controller.
// It draws a solid background, a fixed wall border and a square box. The box
// moves SPEED pixels per frame on each axis and bounces off the walls. The
// image is registered once per pixel tick, and the syncs are delayed by the
// same tick so they stay aligned with rgb.
//
// Ports:
//   clk_100MHz   system clock
//   reset_n      asynchronous active-low reset
//   p_tick       pixel enable, one clk_100MHz cycle in four
//   video_on     visible-area flag, aligned with x/y
//   hsync/vsync  active-low syncs from the timing controller
//   x, y         current pixel column / row
//   enable       1 = box moves each frame, 0 = box frozen
//   rgb          registered pixel colour {R,G,B} (RGB444)
//   hsync_out    hsync delayed one pixel tick
//   vsync_out    vsync delayed one pixel tick
//   frame_count  frames seen since reset, wraps at 255
// ---------------------------------------------------------------------------
module bouncing_box_renderer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          BOX_SIZE   = 32,
    parameter int          SPEED      = 2,
    parameter int          BORDER     = 8,
    parameter logic [11:0] BOX_COLOR  = 12'hF00,
    parameter logic [11:0] WALL_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h00F
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        enable,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  frame_count
);

    // All geometry is handled at 11 bits so box_x + BOX_SIZE never wraps.
    localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
    localparam logic [10:0] SPD_W   = 11'(SPEED);
    localparam logic [10:0] BORD_W  = 11'(BORDER);
    localparam logic [10:0] H_WALL  = 11'(H_RES - BORDER);
    localparam logic [10:0] V_WALL  = 11'(V_RES - BORDER);
    localparam logic [10:0] X_MAX   = 11'(H_RES - BORDER - BOX_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_RES - BORDER - BOX_SIZE);
    localparam logic [10:0] X_START = 11'((H_RES - BOX_SIZE) / 2);
    localparam logic [10:0] Y_START = 11'((V_RES - BOX_SIZE) / 2);

    typedef enum logic {
        MOVE_POS = 1'b0,
        MOVE_NEG = 1'b1
    } dir_e;

    typedef struct packed {
        logic [10:0] pos;
        dir_e        dir;
    } axis_t;

    // One frame of motion for one axis: advance, or clamp to the limit and
    // reverse when the next step would reach or cross it.
    function automatic axis_t axis_step(input logic [10:0] pos, input dir_e dir,
                                        input logic [10:0] lo, input logic [10:0] hi);
        axis_t r;
        r.pos = pos;
        r.dir = dir;
        if (dir == MOVE_POS) begin
            if (pos + SPD_W >= hi) begin
                r.pos = hi;
                r.dir = MOVE_NEG;
            end else begin
                r.pos = pos + SPD_W;
            end
        end else begin
            if (pos <= lo + SPD_W) begin
                r.pos = lo;
                r.dir = MOVE_POS;
            end else begin
                r.pos = pos - SPD_W;
            end
        end
        return r;
    endfunction

    logic [11:0] rgb_q, rgb_d;
    logic        hsync_out_q, hsync_out_d;
    logic        vsync_out_q, vsync_out_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    dir_e        dir_x_q, dir_x_d;
    dir_e        dir_y_q, dir_y_d;

    logic        frame_tick;
    logic        in_box;
    logic        in_wall;
    axis_t       step_x;
    axis_t       step_y;

    // vsync falling edge sampled on pixel ticks; lands in vertical blanking,
    // so the box never moves while the visible area is being drawn.
    assign frame_tick = p_tick & vsync_q & ~vsync;

    // Pixel pipeline: colour lookup and sync delay.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        rgb_d       = rgb_q;
        hsync_out_d = hsync_out_q;
        vsync_out_d = vsync_out_q;
        vsync_d     = vsync_q;

        in_box  = ({1'b0, x} >= box_x_q) && ({1'b0, x} < box_x_q + SIZE_W) &&
                  ({1'b0, y} >= box_y_q) && ({1'b0, y} < box_y_q + SIZE_W);
        in_wall = ({1'b0, x} < BORD_W) || ({1'b0, x} >= H_WALL) ||
                  ({1'b0, y} < BORD_W) || ({1'b0, y} >= V_WALL);

        if (p_tick) begin
            hsync_out_d = hsync;
            vsync_out_d = vsync;
            vsync_d     = vsync;
            if (!video_on) begin
                rgb_d = 12'h000;
            end else if (in_box) begin
                rgb_d = BOX_COLOR;
            end else if (in_wall) begin
                rgb_d = WALL_COLOR;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    // Motion FSM (one direction state per axis) and frame counter.
    always_comb begin
        box_x_d       = box_x_q;
        box_y_d       = box_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        frame_count_d = frame_count_q;

        step_x = axis_step(box_x_q, dir_x_q, BORD_W, X_MAX);
        step_y = axis_step(box_y_q, dir_y_q, BORD_W, Y_MAX);

        if (frame_tick) begin
            frame_count_d = frame_count_q + 8'd1;
            if (enable) begin
                box_x_d = step_x.pos;
                dir_x_d = step_x.dir;
                box_y_d = step_y.pos;
                dir_y_d = step_y.dir;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q         <= 12'h000;
            hsync_out_q   <= 1'b1;
            vsync_out_q   <= 1'b1;
            vsync_q       <= 1'b1;
            frame_count_q <= 8'd0;
            box_x_q       <= X_START;
            box_y_q       <= Y_START;
            dir_x_q       <= MOVE_POS;
            dir_y_q       <= MOVE_POS;
        end else begin
            rgb_q         <= rgb_d;
            hsync_out_q   <= hsync_out_d;
            vsync_out_q   <= vsync_out_d;
            vsync_q       <= vsync_d;
            frame_count_q <= frame_count_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync_out   = hsync_out_q;
    assign vsync_out   = vsync_out_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// ---------------------------------------------------------------------------
// tb_bouncing_box_renderer
//
// Drives pixel ticks (one clock in four) with random and targeted x/y/sync
// values and compares rgb, the delayed syncs and frame_count against a
// behavioural model of the box position kept as plain integers.
// ---------------------------------------------------------------------------
module tb_bouncing_box_renderer;

    logic        clk_100MHz = 1'b0;
    logic        reset_n    = 1'b0;
    logic        p_tick     = 1'b0;
    logic        video_on   = 1'b0;
    logic        hsync      = 1'b1;
    logic        vsync      = 1'b1;
    logic [9:0]  x          = '0;
    logic [9:0]  y          = '0;
    logic        enable     = 1'b1;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic [7:0]  frame_count;

    bouncing_box_renderer dut (
        .clk_100MHz  (clk_100MHz),
        .reset_n     (reset_n),
        .p_tick      (p_tick),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .x           (x),
        .y           (y),
        .enable      (enable),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .frame_count (frame_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: box top-left corner, direction (+1/-1), frame count.
    int m_bx, m_by, m_dx, m_dy, m_fc;
    bit m_vs_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bx = 304; m_by = 224; m_dx = 1; m_dy = 1; m_fc = 0; m_vs_prev = 1'b1;
    endtask

    function automatic logic [11:0] ref_colour(input int px, input int py, input bit von);
        if (!von) return 12'h000;
        if (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32) return 12'hF00;
        if (px < 8 || px >= 632 || py < 8 || py >= 472) return 12'hFFF;
        return 12'h00F;
    endfunction

    task automatic model_frame();
        m_fc = (m_fc + 1) % 256;
        if (enable) begin
            if (m_dx > 0) begin
                if (m_bx + 2 >= 600) begin m_bx = 600; m_dx = -1; end else m_bx += 2;
            end else begin
                if (m_bx <= 10) begin m_bx = 8; m_dx = 1; end else m_bx -= 2;
            end
            if (m_dy > 0) begin
                if (m_by + 2 >= 440) begin m_by = 440; m_dy = -1; end else m_by += 2;
            end else begin
                if (m_by <= 10) begin m_by = 8; m_dy = 1; end else m_by -= 2;
            end
        end
    endtask

    // One pixel tick: drive inputs, check outputs after the tick edge, then
    // scramble x/y during the idle cycles and check that outputs hold.
    task automatic pix(input int px, input int py, input bit von, input bit hs, input bit vs);
        logic [11:0] exp_rgb;
        @(negedge clk_100MHz);
        x = 10'(px); y = 10'(py); video_on = von; hsync = hs; vsync = vs; p_tick = 1'b1;
        exp_rgb = ref_colour(px, py, von);
        if (m_vs_prev && !vs) model_frame();
        m_vs_prev = vs;
        @(negedge clk_100MHz);
        p_tick = 1'b0;
        check("rgb", 32'(rgb), 32'(exp_rgb));
        check("hsync_out", 32'(hsync_out), 32'(hs));
        check("vsync_out", 32'(vsync_out), 32'(vs));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
        video_on = 1'($urandom); vsync = 1'b1;
        @(negedge clk_100MHz);
        check("rgb_hold", 32'(rgb), 32'(exp_rgb));
        @(negedge clk_100MHz);
    endtask

    task automatic rand_pix(input bit vs);
        int px, py;
        if ($urandom_range(0, 1) == 0) begin
            px = m_bx + $urandom_range(0, 35) - 2;
            py = m_by + $urandom_range(0, 35) - 2;
        end else begin
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
        end
        pix(px, py, 1'($urandom_range(0, 3) != 0), 1'($urandom), vs);
    endtask

    task automatic frame();
        rand_pix(1'b0);
        rand_pix(1'b1);
    endtask

    // Probe the box edges and the pixels just outside them.
    task automatic probe_box();
        pix(m_bx,      m_by,      1'b1, 1'b1, 1'b1);
        check("probe_tl", 32'(rgb), 32'h0F00);
        pix(m_bx - 1,  m_by,      1'b1, 1'b1, 1'b1);
        pix(m_bx + 31, m_by + 31, 1'b1, 1'b1, 1'b1);
        check("probe_br", 32'(rgb), 32'h0F00);
        pix(m_bx + 32, m_by + 31, 1'b1, 1'b1, 1'b1);
        pix(m_bx,      m_by - 1,  1'b1, 1'b1, 1'b1);
        pix(m_bx + 31, m_by + 32, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk_100MHz);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync_out), 32'h1);
        check("rst_vsync", 32'(vsync_out), 32'h1);
        check("rst_fc", 32'(frame_count), 32'h0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    initial begin
        int fc_hold, bx_hold, by_hold;
        model_reset();
        #23;
        check("init_rgb", 32'(rgb), 32'h0);
        check("init_syncs", 32'({hsync_out, vsync_out}), 32'h3);
        check("init_fc", 32'(frame_count), 32'h0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;

        // Directed pixels.
        pix(0, 0, 1'b1, 1'b0, 1'b1);
        check("wall_corner", 32'(rgb), 32'h0FFF);
        check("hs_delayed", 32'(hsync_out), 32'h0);
        pix(310, 230, 1'b1, 1'b1, 1'b1);
        check("box_center", 32'(rgb), 32'h0F00);
        pix(100, 100, 1'b1, 1'b1, 1'b1);
        check("background", 32'(rgb), 32'h000F);
        pix(100, 100, 1'b0, 1'b1, 1'b1);
        check("blank", 32'(rgb), 32'h0);
        pix(1000, 700, 1'b0, 1'b1, 1'b1);
        check("spurious_xy", 32'(rgb), 32'h0);
        probe_box();

        // First frame: box moves to (306,226).
        frame();
        check("fc_one", 32'(frame_count), 32'h1);
        pix(306, 226, 1'b1, 1'b1, 1'b1);
        check("moved_tl", 32'(rgb), 32'h0F00);
        pix(305, 226, 1'b1, 1'b1, 1'b1);
        check("moved_left", 32'(rgb), 32'h000F);

        // vsync held low for several ticks counts once.
        for (int i = 0; i < 3; i++) rand_pix(1'b0);
        rand_pix(1'b1);
        check("fc_single_edge", 32'(frame_count), 32'h2);

        // 148 frames from reset reach the right wall.
        async_reset();
        for (int i = 0; i < 148; i++) frame();
        pix(600, m_by, 1'b1, 1'b1, 1'b1);
        check("right_limit", 32'(rgb), 32'h0F00);
        pix(631, m_by, 1'b1, 1'b1, 1'b1);
        check("right_edge", 32'(rgb), 32'h0F00);
        pix(599, m_by, 1'b1, 1'b1, 1'b1);
        probe_box();
        frame();
        pix(598, m_by, 1'b1, 1'b1, 1'b1);
        check("bounced_left", 32'(rgb), 32'h0F00);
        pix(630, m_by, 1'b1, 1'b1, 1'b1);
        check("bounced_trail", 32'(rgb), 32'h000F);

        // Frozen box: position holds, frame_count advances.
        enable = 1'b0;
        fc_hold = m_fc; bx_hold = m_bx; by_hold = m_by;
        for (int i = 0; i < 10; i++) frame();
        check("frozen_fc", 32'(frame_count), 32'((fc_hold + 10) % 256));
        pix(bx_hold, by_hold, 1'b1, 1'b1, 1'b1);
        check("frozen_pos", 32'(rgb), 32'h0F00);
        probe_box();
        enable = 1'b1;
        frame();
        probe_box();

        // Random enable over enough frames to bounce on every wall.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            frame();
            if (i % 25 == 0) probe_box();
        end
        enable = 1'b1;

        // Mid-line reset after 50 frames.
        for (int i = 0; i < 50; i++) frame();
        async_reset();
        probe_box();
        pix(303, 224, 1'b1, 1'b1, 1'b1);
        check("reset_pos_left", 32'(rgb), 32'h000F);
        pix(304, 224, 1'b1, 1'b1, 1'b1);
        check("reset_pos_tl", 32'(rgb), 32'h0F00);

        // frame_count wraps after 256 frames.
        for (int i = 0; i < 256; i++) frame();
        check("fc_wrap", 32'(frame_count), 32'h0);
        probe_box();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
